// File: rtl/pico_wb_pkg.sv
// Shared types and constants for the picorv32-to-Wishbone classic bridge.
package pico_wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RETRY  = 2'd2,
        RESP   = 2'd3
    } wb_state_e;

    localparam logic [2:0]  WB_CTI_CLASSIC    = 3'b000;
    localparam logic [1:0]  WB_BTE_LINEAR     = 2'b00;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Watchdog counter for an outstanding Wishbone cycle; saturates at TIMEOUT so
// expiry stays asserted once reached, even across retry gaps.
module wb_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] LAST  = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count_r;

    // Count elapsed cycles since the request was issued.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && (count_r != LIMIT)) begin
            count_r <= count_r + TO_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    // The edge that sees TIMEOUT-1 elapsed cycles is the TIMEOUT-th active edge.
    assign expired = (count_r >= LAST);

endmodule

// File: rtl/pico_wb_master.sv
// picorv32 native memory port to single-beat Wishbone B4 classic initiator
// with err/rty handling and a watchdog abort.
module pico_wb_master
    import pico_wb_pkg::*;
#(
    parameter int          TIMEOUT   = 255,
    parameter int          TO_W      = 8,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [29:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        o_bus_err,
    output logic [31:0] o_err_adr
);

    wb_state_e   state_r, state_n;
    logic        cyc_n, ready_n, bus_err_n, we_n;
    logic [29:0] adr_n;
    logic [31:0] dat_n, rdata_n, err_adr_n;
    logic [3:0]  sel_n;
    logic        start_s, expired_s, cnt_en_s, fail_s;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .clr       (start_s),
        .en        (cnt_en_s),
        .expired   (expired_s)
    );

    // Retry gaps still consume the watchdog budget.
    assign cnt_en_s = (state_r == ACTIVE) || (state_r == RETRY);
    // Any real termination beats a coincident timeout.
    assign fail_s   = wb_err_i || (expired_s && !wb_ack_i && !wb_rty_i);

    assign wb_cti_o = WB_CTI_CLASSIC;
    assign wb_bte_o = WB_BTE_LINEAR;

    // Next-state and next-output decode.
    always_comb begin
        state_n   = state_r;
        cyc_n     = wb_cyc_o;
        ready_n   = 1'b0;
        bus_err_n = 1'b0;
        rdata_n   = mem_rdata;
        err_adr_n = o_err_adr;
        adr_n     = wb_adr_o;
        dat_n     = wb_dat_o;
        sel_n     = wb_sel_o;
        we_n      = wb_we_o;
        start_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_valid) begin
                    start_s = 1'b1;
                    state_n = ACTIVE;
                    cyc_n   = 1'b1;
                    adr_n   = mem_addr[31:2];
                    dat_n   = mem_wdata;
                    we_n    = |mem_wstrb;
                    sel_n   = (|mem_wstrb) ? mem_wstrb : 4'hF;
                end else begin
                    state_n = IDLE;
                end
            end
            ACTIVE: begin
                if (fail_s) begin
                    cyc_n     = 1'b0;
                    ready_n   = 1'b1;
                    bus_err_n = 1'b1;
                    rdata_n   = ERR_RDATA;
                    err_adr_n = {wb_adr_o, 2'b00};
                    state_n   = RESP;
                end else if (wb_ack_i) begin
                    cyc_n   = 1'b0;
                    ready_n = 1'b1;
                    if (!wb_we_o) begin
                        rdata_n = wb_dat_i;
                    end else begin
                        rdata_n = mem_rdata;
                    end
                    state_n = RESP;
                end else if (wb_rty_i) begin
                    cyc_n   = 1'b0;
                    state_n = RETRY;
                end else begin
                    state_n = ACTIVE;
                end
            end
            RETRY: begin
                cyc_n   = 1'b1;
                state_n = ACTIVE;
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                cyc_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; cyc and stb share one source.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r   <= IDLE;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= 30'd0;
            wb_dat_o  <= 32'd0;
            wb_sel_o  <= 4'd0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            o_bus_err <= 1'b0;
            o_err_adr <= 32'd0;
        end else begin
            state_r   <= state_n;
            wb_cyc_o  <= cyc_n;
            wb_stb_o  <= cyc_n;
            wb_we_o   <= we_n;
            wb_adr_o  <= adr_n;
            wb_dat_o  <= dat_n;
            wb_sel_o  <= sel_n;
            mem_ready <= ready_n;
            mem_rdata <= rdata_n;
            o_bus_err <= bus_err_n;
            o_err_adr <= err_adr_n;
        end
    end

endmodule
